// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller between the uart_rx deserialiser and
// the consuming logic.
//   - enables/disables the receiver (registered uart_rx_en)
//   - buffers received words in a first-word-fall-through FIFO (ready/valid)
//   - pulses rx_idle once after IDLE_CYCLES of receive silence (packet end)
//   - tracks BREAK and FIFO overflow with sticky status flags
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   ctrl_en                     level, 1 = receive enabled
//   flush, clr_status           single-cycle pulses: empty FIFO / clear flags
//   uart_rx_en                  registered enable to uart_rx
//   uart_rx_valid/break/data    strobe, BREAK qualifier and word from uart_rx
//   out_valid/out_ready/out_data FIFO head, ready/valid handshake
//   rx_idle                     one-cycle end-of-packet pulse
//   fifo_count                  current occupancy
//   overflow, break_seen        sticky status flags
module uart_rx_ctrl #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int IDLE_CYCLES  = 52080
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ctrl_en,
    input  logic                          flush,
    input  logic                          clr_status,
    output logic                          uart_rx_en,
    input  logic                          uart_rx_valid,
    input  logic                          uart_rx_break,
    input  logic [PAYLOAD_BITS-1:0]       uart_rx_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PAYLOAD_BITS-1:0]       out_data,
    output logic                          rx_idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          break_seen
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [15:0]   IDLE_C  = 16'(IDLE_CYCLES);

    typedef enum logic [1:0] {
        ST_DIS = 2'd0,
        ST_RUN = 2'd1,
        ST_BRK = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    uart_rx_en_q;
    logic [15:0]             timer_q, timer_d, timer_inc_s;
    logic                    armed_q, armed_d;
    logic                    rx_idle_q, rx_idle_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d, break_seen_q, break_seen_d;
    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                    pop_s, full_s, wr_s, drop_s, brk_set_s;

    assign out_valid   = (count_q != {CW{1'b0}});
    assign pop_s       = out_valid & out_ready;
    assign full_s      = (count_q == DEPTH_C);
    // The timer saturates at IDLE_CYCLES so a long silence cannot wrap it.
    assign timer_inc_s = (timer_q == IDLE_C) ? timer_q : (timer_q + 16'd1);

    // Next-state logic for the control FSM, idle timer and strobe handling.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        armed_d   = armed_q;
        rx_idle_d = 1'b0;
        wr_s      = 1'b0;
        drop_s    = 1'b0;
        brk_set_s = 1'b0;
        case (state_q)
            ST_DIS: begin
                // Disarmed here so no rx_idle fires before the first word after enable.
                armed_d = 1'b0;
                if (ctrl_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DIS;
                end
            end
            ST_RUN: begin
                if (uart_rx_valid) begin
                    timer_d = 16'd0;
                    if (uart_rx_break) begin
                        brk_set_s = 1'b1;
                        armed_d   = 1'b0;
                        state_d   = ST_BRK;
                    end else begin
                        armed_d = 1'b1;
                        // A full FIFO still accepts when the head leaves this cycle.
                        if (!full_s || pop_s) begin
                            wr_s = 1'b1;
                        end else begin
                            drop_s = 1'b1;
                        end
                    end
                end else if (armed_q) begin
                    timer_d = timer_inc_s;
                    if (timer_inc_s == IDLE_C) begin
                        rx_idle_d = 1'b1;
                        armed_d   = 1'b0;
                    end else begin
                        armed_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q;
                end
                // A strobe in the disabling cycle is still processed above.
                if (!ctrl_en) begin
                    state_d = ST_DIS;
                end else begin
                    state_d = state_d;
                end
            end
            ST_BRK: begin
                armed_d = 1'b0;
                if (uart_rx_valid) begin
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_inc_s;
                end
                if (!ctrl_en) begin
                    state_d = ST_DIS;
                end else if (timer_d == IDLE_C) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_BRK;
                end
            end
            default: begin
                state_d = ST_DIS;
                armed_d = 1'b0;
            end
        endcase
    end

    // Next-state logic for FIFO pointers, occupancy and sticky flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // Set events beat a same-cycle clear; a flushed word never sets overflow.
        if (drop_s && !flush) begin
            overflow_d = 1'b1;
        end else if (clr_status) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (brk_set_s) begin
            break_seen_d = 1'b1;
        end else if (clr_status) begin
            break_seen_d = 1'b0;
        end else begin
            break_seen_d = break_seen_q;
        end
    end

    // State, timer, FIFO control and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_DIS;
            uart_rx_en_q <= 1'b0;
            timer_q      <= 16'd0;
            armed_q      <= 1'b0;
            rx_idle_q    <= 1'b0;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            overflow_q   <= 1'b0;
            break_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            uart_rx_en_q <= (state_d != ST_DIS);
            timer_q      <= timer_d;
            armed_q      <= armed_d;
            rx_idle_q    <= rx_idle_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            break_seen_q <= break_seen_d;
        end
    end

    // FIFO storage; contents need no reset because out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (wr_s && !flush) begin
            mem_q[wr_ptr_q] <= uart_rx_data;
        end
    end

    assign uart_rx_en = uart_rx_en_q;
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : {PAYLOAD_BITS{1'b0}};
    assign rx_idle    = rx_idle_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign break_seen = break_seen_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with FIFO_DEPTH=4, IDLE_CYCLES=20.
// Expected words go into a scoreboard queue when a strobe is driven that
// should be accepted; they are popped and compared whenever the bench sees
// an out_valid & out_ready handshake about to be taken.
module tb_uart_rx_ctrl;

    localparam int IDLE = 20;

    logic       clk;
    logic       resetn;
    logic       ctrl_en;
    logic       flush;
    logic       clr_status;
    logic       uart_rx_en;
    logic       uart_rx_valid;
    logic       uart_rx_break;
    logic [7:0] uart_rx_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       rx_idle;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       break_seen;

    uart_rx_ctrl #(
        .PAYLOAD_BITS (8),
        .FIFO_DEPTH   (4),
        .IDLE_CYCLES  (IDLE)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ctrl_en       (ctrl_en),
        .flush         (flush),
        .clr_status    (clr_status),
        .uart_rx_en    (uart_rx_en),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_break (uart_rx_break),
        .uart_rx_data  (uart_rx_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .rx_idle       (rx_idle),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .break_seen    (break_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       wr;
        logic [2:0] exp_count;
        logic       exp_ovf;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         idle_cnt = 0;
    int         idle_cyc = -1;
    int         c0 = 0;
    logic [7:0] exp_q [$];
    vec_t       vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: score a pending pop, step past the edge, note rx_idle.
    task automatic tick();
        logic [7:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=no_word", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", {24'd0, out_data}, {24'd0, e});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rx_idle === 1'b1) begin
            idle_cnt++;
            idle_cyc = cyc;
        end
    endtask

    task automatic strobe(input logic [7:0] d, input logic brk, input logic expect_wr);
        uart_rx_data  = d;
        uart_rx_break = brk;
        uart_rx_valid = 1'b1;
        if (expect_wr) exp_q.push_back(d);
        tick();
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; ctrl_en = 1'b0; flush = 1'b0; clr_status = 1'b0;
        uart_rx_valid = 1'b0; uart_rx_break = 1'b0; uart_rx_data = 8'd0;
        out_ready = 1'b0;

        vecs[0] = '{8'h10, 1'b1, 3'd1, 1'b0};
        vecs[1] = '{8'h11, 1'b1, 3'd2, 1'b0};
        vecs[2] = '{8'h12, 1'b1, 3'd3, 1'b0};
        vecs[3] = '{8'h13, 1'b1, 3'd4, 1'b0};
        vecs[4] = '{8'h14, 1'b0, 3'd4, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_en", {31'd0, uart_rx_en}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_rx_idle", {31'd0, rx_idle}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_break", {31'd0, break_seen}, 32'd0);
        resetn = 1'b1;
        tick();

        // 1. Basic receive and idle
        ctrl_en = 1'b1;
        tick();
        chk("en_rx_en", {31'd0, uart_rx_en}, 32'd1);
        out_ready = 1'b1;
        idle_cnt = 0;
        strobe(8'h41, 1'b0, 1'b1);
        chk("t1_valid_41", {31'd0, out_valid}, 32'd1);
        chk("t1_data_41", {24'd0, out_data}, 32'h41);
        repeat (4) tick();
        strobe(8'h42, 1'b0, 1'b1);
        c0 = cyc;
        chk("t1_valid_42", {31'd0, out_valid}, 32'd1);
        chk("t1_data_42", {24'd0, out_data}, 32'h42);
        while (cyc < c0 + 30) tick();
        chk("t1_idle_count", idle_cnt, 32'd1);
        chk("t1_idle_time", idle_cyc - c0, IDLE);
        chk("t1_sb_empty", exp_q.size(), 32'd0);

        // 2. Fill and overflow, table driven
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe(vecs[i].data, 1'b0, vecs[i].wr);
            chk("t2_count", {29'd0, fifo_count}, {29'd0, vecs[i].exp_count});
            chk("t2_ovf", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
            chk("t2_head_hold", {24'd0, out_data}, 32'h10);
        end
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t2_drained", {29'd0, fifo_count}, 32'd0);
        chk("t2_sb_empty", exp_q.size(), 32'd0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("t2_ovf_clr", {31'd0, overflow}, 32'd0);

        // 3. Full with simultaneous write and pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(8'h20 + 8'(i), 1'b0, 1'b1);
        chk("t3_full", {29'd0, fifo_count}, 32'd4);
        out_ready = 1'b1;
        strobe(8'h55, 1'b0, 1'b1);
        out_ready = 1'b0;
        chk("t3_count_stays", {29'd0, fifo_count}, 32'd4);
        chk("t3_no_ovf", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t3_drained", {29'd0, fifo_count}, 32'd0);
        chk("t3_sb_empty", exp_q.size(), 32'd0);

        // 4. BREAK
        idle_cnt = 0;
        strobe(8'hAA, 1'b1, 1'b0);
        chk("t4_break_seen", {31'd0, break_seen}, 32'd1);
        chk("t4_state_brk", {30'd0, dut.state_q}, 32'd2);
        repeat (9) tick();
        strobe(8'h00, 1'b0, 1'b0);
        c0 = cyc;
        while (cyc < c0 + IDLE - 1) tick();
        chk("t4_still_brk", {30'd0, dut.state_q}, 32'd2);
        tick();
        chk("t4_back_run", {30'd0, dut.state_q}, 32'd1);
        repeat (30) tick();
        chk("t4_no_idle", idle_cnt, 32'd0);
        chk("t4_no_write", {29'd0, fifo_count}, 32'd0);
        out_ready = 1'b0;
        strobe(8'h33, 1'b0, 1'b1);
        chk("t4_count_33", {29'd0, fifo_count}, 32'd1);
        chk("t4_data_33", {24'd0, out_data}, 32'h33);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 5. Sticky vs clear, flush priority
        for (int i = 0; i < 4; i++) strobe(8'h60 + 8'(i), 1'b0, 1'b1);
        clr_status = 1'b1;
        strobe(8'h64, 1'b0, 1'b0);
        clr_status = 1'b0;
        chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("t5_break_clr", {31'd0, break_seen}, 32'd0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        flush = 1'b1;
        strobe(8'h70, 1'b0, 1'b0);
        flush = 1'b0;
        exp_q.delete();
        chk("t5_flush_count", {29'd0, fifo_count}, 32'd0);
        chk("t5_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_flush_no_ovf", {31'd0, overflow}, 32'd0);
        strobe(8'h71, 1'b0, 1'b1);
        chk("t5_after_flush_cnt", {29'd0, fifo_count}, 32'd1);
        chk("t5_after_flush_data", {24'd0, out_data}, 32'h71);

        // 6. Disable and reset
        ctrl_en = 1'b0;
        strobe(8'h72, 1'b0, 1'b1);
        chk("t6_rx_en_off", {31'd0, uart_rx_en}, 32'd0);
        chk("t6_last_written", {29'd0, fifo_count}, 32'd2);
        tick();
        strobe(8'h73, 1'b0, 1'b0);
        chk("t6_ignored", {29'd0, fifo_count}, 32'd2);
        ctrl_en = 1'b1;
        tick();
        strobe(8'h75, 1'b0, 1'b1);
        chk("t6_occ3", {29'd0, fifo_count}, 32'd3);
        #2;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_count", {29'd0, fifo_count}, 32'd0);
        chk("t6_rst_rx_en", {31'd0, uart_rx_en}, 32'd0);
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        chk("t6_reenable", {31'd0, uart_rx_en}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
